// File: rtl/collision_scan.sv
// collision_scan: walks the 16 cells of the 4x4 piece window, reads the
// playfield for every filled in-bounds cell and reports one collision verdict.
// A filled cell collides if it lies past a field edge or lands on an occupied
// field cell. Edge hits are found without a read so field_index never aliases.
module collision_scan #(
  parameter int FIELD_W = 20,
  parameter int FIELD_H = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  block_pos_x,
  input  logic [4:0]  block_pos_y,
  input  logic [15:0] shape,
  output logic [4:0]  b_x,
  output logic [4:0]  b_y,
  input  logic [4:0]  block_index,
  input  logic [8:0]  field_index,
  output logic        field_rd_en,
  output logic [8:0]  field_rd_addr,
  input  logic        field_rd_data,
  output logic        busy,
  output logic        done,
  output logic        collision
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [5:0] FW6 = 6'(FIELD_W);
  localparam logic [5:0] FH6 = 6'(FIELD_H);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       oob_hit_q, oob_hit_d;
  logic       hit_q, hit_d;
  logic       coll_q, coll_d;

  logic [5:0] sum_x, sum_y;
  logic       sb, oob, rd_en, hit_now;

  // The counter wraps to 0 after cell 15, so b_x/b_y are 0 outside SCAN.
  assign b_x = {3'b000, cnt_q[1:0]};
  assign b_y = {3'b000, cnt_q[3:2]};

  // Per-cell evaluation of the presented cell; 6-bit sums cannot wrap.
  always_comb begin
    sum_x   = {1'b0, block_pos_x} + {1'b0, b_x};
    sum_y   = {1'b0, block_pos_y} + {1'b0, b_y};
    sb      = block_index[4] ? 1'b0 : shape[block_index[3:0]];
    oob     = (sum_x >= FW6) || (sum_y >= FH6);
    rd_en   = (state_q == SCAN) && sb && !oob;
    hit_now = hit_q | oob_hit_q | (pend_q & field_rd_data);
  end

  assign field_rd_en   = rd_en;
  assign field_rd_addr = rd_en ? field_index : 9'd0;
  assign busy          = (state_q == SCAN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign collision     = coll_q;

  // Next-state logic: cell stepping and hit accumulation one cycle behind the read.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = 1'b0;
    oob_hit_d = 1'b0;
    hit_d     = hit_q;
    coll_d    = coll_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          cnt_d   = 4'd0;
          hit_d   = 1'b0;
        end
      end
      SCAN: begin
        hit_d     = hit_now;
        pend_d    = rd_en;
        oob_hit_d = sb & oob;
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = DRAIN;
      end
      DRAIN: begin
        hit_d   = hit_now;
        coll_d  = hit_now;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers; reset clears everything including the verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      pend_q    <= 1'b0;
      oob_hit_q <= 1'b0;
      hit_q     <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      oob_hit_q <= oob_hit_d;
      hit_q     <= hit_d;
      coll_q    <= coll_d;
    end
  end

endmodule

// File: tb/tb_collision_scan.sv
// Bench for collision_scan: models the index stage and playfield memory,
// applies a directed table, hand-written corner sequences and random scans.
module tb_collision_scan;

  localparam int FW = 20;
  localparam int FH = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  block_pos_x, block_pos_y;
  logic [15:0] shape;
  logic [4:0]  b_x, b_y;
  logic [4:0]  block_index;
  logic [8:0]  field_index;
  logic        field_rd_en;
  logic [8:0]  field_rd_addr;
  logic        field_rd_data;
  logic        busy, done, collision;

  logic        rot;
  bit          fmem [FW*FH];
  int          read_log [$];
  int          exp_q [$];
  int          checks = 0;
  int          errors = 0;

  collision_scan #(.FIELD_W(FW), .FIELD_H(FH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .block_pos_x(block_pos_x), .block_pos_y(block_pos_y), .shape(shape),
    .b_x(b_x), .b_y(b_y), .block_index(block_index), .field_index(field_index),
    .field_rd_en(field_rd_en), .field_rd_addr(field_rd_addr),
    .field_rd_data(field_rd_data), .busy(busy), .done(done), .collision(collision)
  );

  always #5 clk = ~clk;

  // Index stage: identity or 180-degree rotation, row stride FW.
  logic [3:0] cell_n;
  assign cell_n      = {b_y[1:0], b_x[1:0]};
  assign block_index = {1'b0, rot ? ~cell_n : cell_n};
  assign field_index = 9'((int'(block_pos_y) + int'(b_y)) * FW + int'(block_pos_x) + int'(b_x));

  // Field memory: data valid the cycle after a sampled read; stale otherwise.
  always @(posedge clk) begin
    if (field_rd_en) field_rd_data <= (int'(field_rd_addr) < FW*FH) ? fmem[field_rd_addr] : 1'b1;
  end

  // Read monitor.
  always @(negedge clk) begin
    if (field_rd_en) read_log.push_back(int'(field_rd_addr));
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reads(input string name);
    int bad = 0;
    if (read_log.size() != exp_q.size()) bad = 1;
    else foreach (exp_q[i]) if (read_log[i] != exp_q[i]) bad = 1;
    chk({name, " read_cnt"}, read_log.size(), exp_q.size());
    chk({name, " read_addrs"}, bad, 0);
  endtask

  // Reference: a filled cell collides if off-field or on an occupied cell;
  // only filled in-field cells are read, in row-major window order.
  task automatic ref_scan(output bit coll);
    int x, y, bi;
    coll = 0;
    exp_q.delete();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        bi = rot ? 15 - (r*4 + c) : r*4 + c;
        if (shape[bi]) begin
          x = int'(block_pos_x) + c;
          y = int'(block_pos_y) + r;
          if (x >= FW || y >= FH) coll = 1;
          else begin
            exp_q.push_back(y*FW + x);
            if (fmem[y*FW + x]) coll = 1;
          end
        end
      end
    end
  endtask

  // Runs one scan; cycle 0 is the start cycle. Watches 40 cycles after start.
  task automatic do_scan(input bit pulse_extra, output int done_cyc, output int ndone,
                         output bit coll, output bit busy_ok);
    read_log.delete();
    done_cyc = -1; ndone = 0; coll = 0; busy_ok = 1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      start = pulse_extra && (k == 5 || k == 18);
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin done_cyc = k; coll = collision; end
      end
      if (busy !== (k <= 17)) busy_ok = 0;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  typedef struct packed {
    logic [15:0]     shape;
    logic [4:0]      px;
    logic [4:0]      py;
    logic [9:0]      setbit;   // 10'h3FF: field left empty
    logic            pulse;
    logic            coll;
    logic [2:0]      nrd;
    logic [3:0][8:0] addrs;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int  dc, nd;
    bit  c, bok, rc;
    string nm;

    vecs[0] = '{shape:16'h000F, px:5'd0,  py:5'd0,  setbit:10'h3FF, pulse:1'b0, coll:1'b0, nrd:3'd4, addrs:{9'd3, 9'd2, 9'd1, 9'd0}};
    vecs[1] = '{shape:16'h0001, px:5'd3,  py:5'd5,  setbit:10'd103, pulse:1'b0, coll:1'b1, nrd:3'd1, addrs:{9'd0, 9'd0, 9'd0, 9'd103}};
    vecs[2] = '{shape:16'h0001, px:5'd3,  py:5'd5,  setbit:10'h3FF, pulse:1'b0, coll:1'b0, nrd:3'd1, addrs:{9'd0, 9'd0, 9'd0, 9'd103}};
    vecs[3] = '{shape:16'h0008, px:5'd17, py:5'd0,  setbit:10'h3FF, pulse:1'b0, coll:1'b1, nrd:3'd0, addrs:'0};
    vecs[4] = '{shape:16'h0008, px:5'd16, py:5'd0,  setbit:10'h3FF, pulse:1'b0, coll:1'b0, nrd:3'd1, addrs:{9'd0, 9'd0, 9'd0, 9'd19}};
    vecs[5] = '{shape:16'h1000, px:5'd0,  py:5'd21, setbit:10'h3FF, pulse:1'b0, coll:1'b1, nrd:3'd0, addrs:'0};
    vecs[6] = '{shape:16'h1000, px:5'd0,  py:5'd20, setbit:10'h3FF, pulse:1'b0, coll:1'b0, nrd:3'd1, addrs:{9'd0, 9'd0, 9'd0, 9'd460}};
    vecs[7] = '{shape:16'h0000, px:5'd7,  py:5'd9,  setbit:10'h3FF, pulse:1'b1, coll:1'b0, nrd:3'd0, addrs:'0};

    rst = 1'b1; start = 1'b0; rot = 1'b0; field_rd_data = 1'b0;
    block_pos_x = '0; block_pos_y = '0; shape = '0;
    foreach (fmem[i]) fmem[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset collision", collision, 0);
    chk("reset rd_en", field_rd_en, 0);
    chk("reset rd_addr", field_rd_addr, 0);
    chk("reset b_xy", {b_x, b_y}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int v = 0; v < 8; v++) begin
      foreach (fmem[i]) fmem[i] = 1'b0;
      if (vecs[v].setbit != 10'h3FF) fmem[vecs[v].setbit] = 1'b1;
      shape = vecs[v].shape; block_pos_x = vecs[v].px; block_pos_y = vecs[v].py;
      exp_q.delete();
      for (int i = 0; i < int'(vecs[v].nrd); i++) exp_q.push_back(int'(vecs[v].addrs[i]));
      do_scan(vecs[v].pulse, dc, nd, c, bok);
      nm = $sformatf("vec%0d", v);
      $display("scan %s shape=%h pos=(%0d,%0d) coll=%0d done@%0d ndone=%0d reads=%0d",
               nm, shape, block_pos_x, block_pos_y, c, dc, nd, read_log.size());
      chk({nm, " done_cycle"}, dc, 18);
      chk({nm, " done_count"}, nd, 1);
      chk({nm, " collision"}, c, vecs[v].coll);
      chk({nm, " busy"}, bok, 1);
      chk_reads(nm);
    end

    // Reset mid-scan: first establish collision=1, then abort a colliding scan.
    foreach (fmem[i]) fmem[i] = 1'b0;
    fmem[103] = 1'b1;
    shape = 16'h0001; block_pos_x = 5'd3; block_pos_y = 5'd5;
    do_scan(1'b0, dc, nd, c, bok);
    $display("scan pre_reset coll=%0d done@%0d", c, dc);
    chk("pre_reset collision", c, 1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    $display("scan reset_at_8 busy=%0d done=%0d coll=%0d rd_en=%0d", busy, done, collision, field_rd_en);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst collision", collision, 0);
    chk("midrst rd_en", field_rd_en, 0);
    @(posedge clk); #1 rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    chk("midrst no_done", nd, 0);
    do_scan(1'b0, dc, nd, c, bok);
    $display("scan post_reset coll=%0d done@%0d", c, dc);
    chk("post_reset done_cycle", dc, 18);
    chk("post_reset collision", c, 1);

    // Random scans against the reference model
    for (int t = 0; t < 30; t++) begin
      shape = 16'($urandom) & 16'($urandom);
      block_pos_x = 5'($urandom_range(0, 21));
      block_pos_y = 5'($urandom_range(0, 25));
      rot = 1'($urandom_range(0, 1));
      foreach (fmem[i]) fmem[i] = ($urandom_range(0, 7) == 0);
      ref_scan(rc);
      do_scan(1'b0, dc, nd, c, bok);
      nm = $sformatf("rnd%0d", t);
      $display("scan %s shape=%h pos=(%0d,%0d) rot=%0d coll=%0d exp=%0d done@%0d reads=%0d",
               nm, shape, block_pos_x, block_pos_y, rot, c, rc, dc, read_log.size());
      chk({nm, " done_cycle"}, dc, 18);
      chk({nm, " collision"}, c, rc);
      chk_reads(nm);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
